// File: rtl/bru_pkg.sv
// bru_pkg: shared definitions for the branch resolve unit.
//   - Branch opcode encoding driven by the ID-stage decoder (3 bits).
//   - 2-bit saturating counter type plus increment/decrement helpers.
package bru_pkg;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_BGEZ = 3'd3;
   localparam logic [2:0] BR_BGTZ = 3'd4;
   localparam logic [2:0] BR_BLEZ = 3'd5;
   localparam logic [2:0] BR_BLTZ = 3'd6;
   localparam logic [2:0] BR_RSVD = 3'd7;

   typedef logic [1:0] bru_cnt_t;

   // Increment that sticks at strongly-taken.
   function automatic bru_cnt_t sat_inc(input bru_cnt_t c);
      if (c == 2'b11) begin
         return 2'b11;
      end else begin
         return c + 2'b01;
      end
   endfunction

   // Decrement that sticks at strongly-not-taken.
   function automatic bru_cnt_t sat_dec(input bru_cnt_t c);
      if (c == 2'b00) begin
         return 2'b00;
      end else begin
         return c - 2'b01;
      end
   endfunction

endpackage

// File: rtl/bru_bht.sv
// bru_bht: table of 2-bit saturating branch counters.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (table -> CNT_INIT)
//   rd_idx / rd_cnt    combinational read of the registered table (IF prediction)
//   wr_en / wr_idx /   one-entry training per edge; wr_taken selects
//   wr_taken           increment (taken) or decrement (not taken)
// A read and a write to the same index in one cycle returns the old value.
module bru_bht
   import bru_pkg::*;
#(
   parameter int       BHT_DEPTH = 64,
   parameter int       IDX_W     = $clog2(BHT_DEPTH),
   parameter bru_cnt_t CNT_INIT  = 2'b01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   bru_cnt_t cnt_q [BHT_DEPTH];
   bru_cnt_t cnt_d [BHT_DEPTH];

   assign rd_cnt = cnt_q[rd_idx];

   // Next-state of the table: only the addressed entry moves.
   always_comb begin
      cnt_d = cnt_q;
      if (wr_en) begin
         if (wr_taken) begin
            cnt_d[wr_idx] = sat_inc(cnt_q[wr_idx]);
         end else begin
            cnt_d[wr_idx] = sat_dec(cnt_q[wr_idx]);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter storage; reset forces every entry back to CNT_INIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch resolution with a PC-indexed
// 2-bit counter predictor.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   if_pc             IF-stage PC; if_pred_taken is the counter MSB for it
//   id_valid/id_stall ID-stage qualifiers; a stalled branch does not train
//   id_br_op          branch opcode (bru_pkg encoding)
//   id_pc             ID-stage PC, selects the entry to train
//   id_rd1/id_rd2     forwarded rs/rt operands (signed compare)
//   id_pred_taken     prediction carried down from IF
//   id_taken          resolved outcome (0 for non-branches)
//   id_mispredict     resolved outcome differs from carried prediction
// Optional (macro BRU_STATS_EN): stat_branches / stat_mispred, saturating
// 32-bit counts of trained branches and of trained mispredicts.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int       DATA_W    = 32,
   parameter int       BHT_DEPTH = 64,
   parameter bru_cnt_t CNT_INIT  = 2'b01
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       if_pc,
   output logic              if_pred_taken,
   input  logic              id_valid,
   input  logic              id_stall,
   input  logic [2:0]        id_br_op,
   input  logic [31:0]       id_pc,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic              id_pred_taken,
   output logic              id_taken,
   output logic              id_mispredict
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispred
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic             is_br_s;
   logic             cond_s;
   logic             train_en_s;
   logic [1:0]       rd_cnt_s;
   logic [IDX_W-1:0] if_idx_s;
   logic [IDX_W-1:0] id_idx_s;
   logic             unused_s;

   // Word-aligned PCs: drop the byte offset, keep the low index bits.
   assign if_idx_s = if_pc[IDX_W+1:2];
   assign id_idx_s = id_pc[IDX_W+1:2];
   assign unused_s = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                       id_pc[31:IDX_W+2], id_pc[1:0], rd_cnt_s[0]};

   // Branch condition on signed operands; comparisons against zero use the sign bit.
   always_comb begin
      cond_s = 1'b0;
      case (id_br_op)
         BR_BEQ:  cond_s = (id_rd1 == id_rd2);
         BR_BNE:  cond_s = (id_rd1 != id_rd2);
         BR_BGEZ: cond_s = !id_rd1[DATA_W-1];
         BR_BGTZ: cond_s = !id_rd1[DATA_W-1] && (id_rd1 != {DATA_W{1'b0}});
         BR_BLEZ: cond_s = id_rd1[DATA_W-1] || (id_rd1 == {DATA_W{1'b0}});
         BR_BLTZ: cond_s = id_rd1[DATA_W-1];
         default: cond_s = 1'b0;
      endcase
   end

   assign is_br_s       = id_valid && (id_br_op != BR_NONE) && (id_br_op != BR_RSVD);
   assign id_taken      = is_br_s && cond_s;
   assign id_mispredict = is_br_s && (id_taken != id_pred_taken);
   // A stalled branch keeps resolving but trains only on the cycle it leaves ID.
   assign train_en_s    = is_br_s && !id_stall;
   assign if_pred_taken = rd_cnt_s[1];

   bru_bht #(
      .BHT_DEPTH (BHT_DEPTH),
      .IDX_W     (IDX_W),
      .CNT_INIT  (CNT_INIT)
   ) u_bht (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (if_idx_s),
      .rd_cnt   (rd_cnt_s),
      .wr_en    (train_en_s),
      .wr_idx   (id_idx_s),
      .wr_taken (id_taken)
   );

`ifdef BRU_STATS_EN
   logic [31:0] stat_branches_q, stat_branches_d;
   logic [31:0] stat_mispred_q,  stat_mispred_d;

   // Saturating statistics counters, advanced on training edges only.
   always_comb begin
      stat_branches_d = stat_branches_q;
      stat_mispred_d  = stat_mispred_q;
      if (train_en_s) begin
         if (stat_branches_q != 32'hFFFF_FFFF) begin
            stat_branches_d = stat_branches_q + 32'd1;
         end else begin
            stat_branches_d = stat_branches_q;
         end
         if (id_mispredict && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
         end else begin
            stat_mispred_d = stat_mispred_q;
         end
      end else begin
         stat_branches_d = stat_branches_q;
         stat_mispred_d  = stat_mispred_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches_q <= 32'd0;
         stat_mispred_q  <= 32'd0;
      end else begin
         stat_branches_q <= stat_branches_d;
         stat_mispred_q  <= stat_mispred_d;
      end
   end

   assign stat_branches = stat_branches_q;
   assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
   import bru_pkg::*;

   localparam int DEPTH = 64;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        id_valid;
   logic        id_stall;
   logic [2:0]  id_br_op;
   logic [31:0] id_pc;
   logic [31:0] id_rd1;
   logic [31:0] id_rd2;
   logic        id_pred_taken;
   logic        id_taken;
   logic        id_mispredict;
`ifdef BRU_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;
   int          st_br_m;
   int          st_mp_m;
`endif

   int vectors;
   int miscompares;
   int cnt_m [DEPTH];

   branch_resolve_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if_pc         (if_pc),
      .if_pred_taken (if_pred_taken),
      .id_valid      (id_valid),
      .id_stall      (id_stall),
      .id_br_op      (id_br_op),
      .id_pc         (id_pc),
      .id_rd1        (id_rd1),
      .id_rd2        (id_rd2),
      .id_pred_taken (id_pred_taken),
      .id_taken      (id_taken),
      .id_mispredict (id_mispredict)
`ifdef BRU_STATS_EN
      ,
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int midx(input logic [31:0] pc);
      return int'((pc / 32'd4) % DEPTH);
   endfunction

   function automatic bit ref_pred(input logic [31:0] pc);
      return cnt_m[midx(pc)] >= 2;
   endfunction

   function automatic bit ref_is_br(input logic v, input logic [2:0] op);
      return v && (op >= 3'd1) && (op <= 3'd6);
   endfunction

   function automatic bit ref_taken(input logic v, input logic [2:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
      longint sa;
      sa = longint'($signed(a));
      if (!ref_is_br(v, op)) return 1'b0;
      case (op)
         3'd1:    return a == b;
         3'd2:    return a != b;
         3'd3:    return sa >= 0;
         3'd4:    return sa > 0;
         3'd5:    return sa <= 0;
         3'd6:    return sa < 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit ref_mis();
      return ref_is_br(id_valid, id_br_op) &&
             (ref_taken(id_valid, id_br_op, id_rd1, id_rd2) != id_pred_taken);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) cnt_m[i] = 1;
`ifdef BRU_STATS_EN
      st_br_m = 0;
      st_mp_m = 0;
`endif
   endtask

   // Advance one clock edge and train the model as the DUT should.
   task automatic tick();
      bit tr, tk, mp;
      int ix;
      tr = (rst_n === 1'b1) && ref_is_br(id_valid, id_br_op) && !id_stall;
      tk = ref_taken(id_valid, id_br_op, id_rd1, id_rd2);
      mp = ref_mis();
      ix = midx(id_pc);
      @(posedge clk);
      if (tr) begin
         if (tk) begin
            if (cnt_m[ix] < 3) cnt_m[ix]++;
         end else begin
            if (cnt_m[ix] > 0) cnt_m[ix]--;
         end
`ifdef BRU_STATS_EN
         st_br_m++;
         if (mp) st_mp_m++;
`endif
      end
      #1;
   endtask

   task automatic set_id(input logic v, input logic st, input logic [2:0] op,
                         input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic pr);
      id_valid = v; id_stall = st; id_br_op = op; id_pc = pc;
      id_rd1 = a; id_rd2 = b; id_pred_taken = pr;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      if_pc = 32'h0040_0000;
      #1;
      vectors++;
      if (if_pred_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pred: got %b want 0", if_pred_taken);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         if_pc = 32'h0040_0000 + 32'(i * 4);
         #1;
         vectors++;
         if (if_pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_pred idx%0d: got %b want 0", i, if_pred_taken);
         end
      end
   endtask

   task automatic test_beq_saturate();
      set_id(1'b1, 1'b0, BR_BEQ, 32'h0040_0010, 32'd5, 32'd5, 1'b0);
      if_pc = 32'h0040_0010;
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if (id_taken !== 1'b1 || id_mispredict !== 1'b1) begin
            miscompares++;
            $display("FAIL beq_resolve cyc%0d: got taken=%b mis=%b want 1 1", c, id_taken, id_mispredict);
         end
         tick();
      end
      vectors++;
      if (if_pred_taken !== 1'b1) begin
         miscompares++;
         $display("FAIL beq_trained_pred: got %b want 1", if_pred_taken);
      end
      tick();   // third taken: saturates at 3
      set_id(1'b1, 1'b0, BR_BNE, 32'h0040_0010, 32'd5, 32'd5, 1'b1);
      #1;
      vectors++;
      if (id_taken !== 1'b0 || id_mispredict !== 1'b1) begin
         miscompares++;
         $display("FAIL bne_equal: got taken=%b mis=%b want 0 1", id_taken, id_mispredict);
      end
      tick();   // 3 -> 2, still predicts taken
      vectors++;
      if (if_pred_taken !== 1'b1 || ref_pred(if_pc) !== 1'b1) begin
         miscompares++;
         $display("FAIL beq_saturation: got %b want 1", if_pred_taken);
      end
   endtask

   task automatic test_conditions();
      logic [2:0]  op_t  [5] = '{BR_BLTZ, BR_BGEZ, BR_BGTZ, BR_BLEZ, BR_BNE};
      logic [31:0] a_t   [5] = '{32'h8000_0000, 32'd0, 32'd0, 32'd0, 32'd3};
      logic [31:0] b_t   [5] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd3};
      logic        exp_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         set_id(1'b1, 1'b0, op_t[k], 32'h0040_0100, a_t[k], b_t[k], 1'b0);
         #1;
         vectors++;
         if (id_taken !== exp_t[k] || id_mispredict !== exp_t[k]) begin
            miscompares++;
            $display("FAIL cond%0d op%0d: got taken=%b mis=%b want %b %b",
                     k, op_t[k], id_taken, id_mispredict, exp_t[k], exp_t[k]);
         end
         tick();
      end
   endtask

   task automatic test_stall_gating();
      logic [31:0] pc;
      pc = 32'h0040_0080;
      if_pc = pc;
      set_id(1'b1, 1'b1, BR_BEQ, pc, 32'd7, 32'd7, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (id_taken !== 1'b1 || if_pred_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold cyc%0d: got taken=%b pred=%b want 1 0", c, id_taken, if_pred_taken);
         end
         tick();
      end
      id_stall = 1'b0;
      tick();   // single training step: 1 -> 2
      set_id(1'b1, 1'b0, BR_BNE, pc, 32'd7, 32'd7, 1'b0);
      #1;
      vectors++;
      if (if_pred_taken !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release_pred: got %b want 1", if_pred_taken);
      end
      tick();   // 2 -> 1: proves only one step was taken during the stall
      vectors++;
      if (if_pred_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_one_step: got %b want 0", if_pred_taken);
      end
      set_id(1'b0, 1'b0, BR_BEQ, pc, 32'd7, 32'd7, 1'b1);
      #1;
      vectors++;
      if (id_taken !== 1'b0 || id_mispredict !== 1'b0) begin
         miscompares++;
         $display("FAIL invalid_gate: got taken=%b mis=%b want 0 0", id_taken, id_mispredict);
      end
      tick();
      set_id(1'b1, 1'b0, BR_RSVD, pc, 32'd7, 32'd7, 1'b1);
      #1;
      vectors++;
      if (id_taken !== 1'b0 || id_mispredict !== 1'b0) begin
         miscompares++;
         $display("FAIL rsvd_gate: got taken=%b mis=%b want 0 0", id_taken, id_mispredict);
      end
      tick();
      vectors++;
      if (if_pred_taken !== 1'b0 || cnt_m[midx(pc)] != 1) begin
         miscompares++;
         $display("FAIL gate_table_unchanged: got %b want 0", if_pred_taken);
      end
   endtask

   task automatic test_collision();
      do_reset();
      set_id(1'b1, 1'b0, BR_BEQ, 32'h0000_0110, 32'd1, 32'd1, 1'b0);
      if_pc = 32'h0000_0010;
      #1;
      vectors++;
      if (if_pred_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL collision_same_cycle: got %b want 0", if_pred_taken);
      end
      tick();
      id_valid = 1'b0;
      #1;
      vectors++;
      if (if_pred_taken !== 1'b1) begin
         miscompares++;
         $display("FAIL collision_next_cycle: got %b want 1", if_pred_taken);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
         if ($urandom_range(0, 4) == 0) a = 32'd0;
         set_id(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0),
                3'($urandom_range(0, 7)), {$urandom_range(0, 15), 8'($urandom), 2'b00},
                a, b, 1'($urandom_range(0, 1)));
         if_pc = {$urandom_range(0, 15), 8'($urandom), 2'($urandom)};
         #1;
         vectors++;
         if (id_taken !== ref_taken(id_valid, id_br_op, id_rd1, id_rd2) ||
             id_mispredict !== ref_mis() || if_pred_taken !== ref_pred(if_pc)) begin
            miscompares++;
            $display("FAIL random n%0d op%0d: got t=%b m=%b p=%b want t=%b m=%b p=%b", n, id_br_op,
                     id_taken, id_mispredict, if_pred_taken,
                     ref_taken(id_valid, id_br_op, id_rd1, id_rd2), ref_mis(), ref_pred(if_pc));
         end
`ifdef BRU_STATS_EN
         vectors++;
         if (stat_branches !== 32'(st_br_m) || stat_mispred !== 32'(st_mp_m)) begin
            miscompares++;
            $display("FAIL random_stats n%0d: got %0d/%0d want %0d/%0d", n,
                     stat_branches, stat_mispred, st_br_m, st_mp_m);
         end
`endif
         tick();
      end
   endtask

`ifdef BRU_STATS_EN
   task automatic test_stats();
      logic t;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         t = k[0];
         set_id(1'b1, 1'b0, BR_BEQ, 32'h0040_0200, 32'(k), t ? 32'(k) : 32'(k + 1),
                (k < 3) ? !t : t);
         tick();
      end
      set_id(1'b1, 1'b1, BR_BEQ, 32'h0040_0200, 32'd1, 32'd2, 1'b1);
      tick();   // stalled: not counted
      #1;
      vectors++;
      if (stat_branches !== 32'd10 || stat_mispred !== 32'd3) begin
         miscompares++;
         $display("FAIL stats_counts: got %0d/%0d want 10/3", stat_branches, stat_mispred);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic [31:0] pc;
      pc = 32'h0040_0040;
      if_pc = pc;
      set_id(1'b1, 1'b0, BR_BEQ, pc, 32'd9, 32'd9, 1'b1);
      repeat (3) tick();
      vectors++;
      if (if_pred_taken !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_pred: got %b want 1", if_pred_taken);
      end
      #2;
      rst_n = 1'b0;   // mid-cycle, with a training branch still presented
      #1;
      model_reset();
      vectors++;
      if (if_pred_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset_pred: got %b want 0", if_pred_taken);
      end
`ifdef BRU_STATS_EN
      vectors++;
      if (stat_branches !== 32'd0 || stat_mispred !== 32'd0) begin
         miscompares++;
         $display("FAIL mid_reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispred);
      end
`endif
      tick();   // edge under reset: update lost
      @(negedge clk);
      rst_n = 1'b1;
      id_valid = 1'b0;
      #1;
      vectors++;
      if (if_pred_taken !== 1'b0 || ref_pred(pc) !== 1'b0) begin
         miscompares++;
         $display("FAIL after_reset_pred: got %b want 0", if_pred_taken);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      model_reset();
      set_id(1'b0, 1'b0, BR_NONE, 32'd0, 32'd0, 32'd0, 1'b0);
      if_pc = 32'd0;
      test_reset();
      test_beq_saturate();
      test_conditions();
      test_stall_gating();
      test_collision();
      test_random();
`ifdef BRU_STATS_EN
      test_stats();
`endif
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor of the ID-stage branch comparator in the pipelined MIPS core.
- Resolves conditional branches (beq/bne/bgez/bgtz/blez/bltz) in ID from the forwarded operands.
- Adds a PC-indexed table of 2-bit saturating counters, read in IF to predict branches and trained in ID at resolution.
- Reports taken, mispredict and prediction outputs to the hazard/PC-select logic.

Parameters:
- DATA_W, 32, operand width in bits.
- BHT_DEPTH, 64, number of counter entries; power of two, ≥2.
- IDX_W, $clog2(BHT_DEPTH), table index width (derived; do not override).
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  PC of the instruction in IF.
- if_pred_taken  out  1  prediction for if_pc.
- id_valid  in  1  a valid instruction is in ID.
- id_stall  in  1  ID held this cycle; suppresses training.
- id_br_op  in  3  branch opcode (package encoding).
- id_pc  in  32  PC of the instruction in ID.
- id_rd1  in  DATA_W  forwarded rs value.
- id_rd2  in  DATA_W  forwarded rt value.
- id_pred_taken  in  1  prediction carried from IF with this instruction.
- id_taken  out  1  resolved branch outcome.
- id_mispredict  out  1  outcome differs from the carried prediction.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. While rst_n=0, every counter is CNT_INIT.
- Outputs are combinational from state and inputs, so they hold no reset value. During reset, if_pred_taken = CNT_INIT[1] = 0.
- Index: idx(pc) = pc[IDX_W+1:2]. Aliasing between PCs is allowed.
- Prediction:
  - if_pred_taken = counter[idx(if_pc)][1].
  - Zero latency; reads the registered table only.
- Resolution (zero latency, all conditions signed on DATA_W):
  - BEQ: rd1 == rd2.
  - BNE: rd1 != rd2.
  - BGEZ: rd1 ≥ 0.
  - BGTZ: rd1 > 0.
  - BLEZ: rd1 ≤ 0.
  - BLTZ: rd1 < 0.
  - BR_NONE and the reserved code (7): id_taken = 0.
- Gating:
  - is_br = id_valid && id_br_op ∈ {1..6}.
  - id_taken is forced to 0 when !is_br.
  - id_mispredict = is_br && (id_taken != id_pred_taken).
- Training:
  - On the rising edge when is_br && !id_stall, counter[idx(id_pc)] is updated.
  - Taken: increment, saturating at 3.
  - Not taken: decrement, saturating at 0.
  - No other entry changes.
- Stall: id_stall=1 means no update. The outputs stay valid, so a branch held for N cycles trains exactly once, on the cycle it leaves ID.
- Same-index collision: if idx(if_pc) == idx(id_pc) in a training cycle, if_pred_taken returns the pre-update value. There is no bypass.
- Reset mid-operation: all counters return to CNT_INIT immediately. An in-flight update is lost.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - Adds ports stat_branches out 32 and stat_mispred out 32.
  - Both are registers, reset to 0.
  - stat_branches increments on every training edge.
  - stat_mispred increments on training edges where id_mispredict=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package bru_pkg holds:
  - Opcode localparams BR_NONE=3'd0, BR_BEQ=1, BR_BNE=2, BR_BGEZ=3, BR_BGTZ=4, BR_BLEZ=5, BR_BLTZ=6.
  - 2-bit counter typedef.
  - Saturating increment/decrement functions.
- The decoder mapping Instr to id_br_op lives in the ID stage, not in this block.
- One natural sub-module, bru_bht: counter array, read port, write port, reset.
- Condition evaluation and the statistics counters stay in the top module.

Test Plan:
- Reset, then if_pc=0x0040_0000 -> if_pred_taken=0. After rst_n rises, every index still predicts 0.
- BEQ at id_pc=0x0040_0010, rd1=rd2=5, id_pred_taken=0, two consecutive cycles -> id_taken=1 and id_mispredict=1 both cycles. The entry goes 01→10→11, so if_pred_taken=1 for PC 0x0040_0010. A third taken cycle keeps it at 11 (saturation).
- BLTZ with rd1=32'h8000_0000, then BGEZ with rd1=0, BGTZ with rd1=0, BLEZ with rd1=0 -> id_taken = 1, 1, 0, 1 respectively. BNE with rd1=3, rd2=3 -> 0.
- BEQ taken held with id_stall=1 for 3 cycles, then released -> the counter moves exactly one step. id_valid=0 or id_br_op=7 -> id_taken=0, id_mispredict=0, table unchanged.
- if_pc and id_pc both map to index 4 (0x10 and 0x110, BHT_DEPTH=64) with a taken update on an entry at 01 -> if_pred_taken=0 in that cycle and 1 on the next cycle.
- With BRU_STATS_EN: 10 resolved branches including 3 mispredicts -> stat_branches=10, stat_mispred=3. Asserting rst_n=0 asynchronously mid-cycle clears both counters and the table before the next edge.
